// File: rtl/hub_slot.sv
// ---------------------------------------------------------------------------
// hub_slot -- hub time-slot sequencer
//
// Generates the hub/cog bus enable strobe and the rotating one-hot slot owner
// that the hub and all eight cogs use to share hub memory and the sys/lock
// logic round-robin. Each slot lasts two clk_cog cycles (one idle, one with
// ena_bus high), so every cog's slot recurs every 16 cycles. The slot order
// never changes, which keeps the fixed pipeline offsets inside the hub valid.
//
// Optional feature (macro HUB_SLOT_STALL_EN): a debug stall that freezes the
// rotation on a slot boundary. Without the macro, stall is ignored and
// stall_ack is tied low.
//
// Ports:
//   clk_cog   in   core clock, all state on rising edge
//   nres      in   asynchronous active-low reset
//   stall     in   debug freeze request (level)
//   ena_bus   out  bus enable, high one cycle in two while running
//   bus_sel   out  [7:0] one-hot owner of the current slot (bit n = cog n)
//   bus_nxt   out  [7:0] one-hot owner of the following slot
//   slot      out  [2:0] binary index of the bus_sel bit
//   rev_cnt   out  [15:0] completed full rotations, wraps mod 2^16
//   stall_ack out  high while frozen
// ---------------------------------------------------------------------------
module hub_slot (
    input  logic        clk_cog,
    input  logic        nres,
    input  logic        stall,
    output logic        ena_bus,
    output logic [7:0]  bus_sel,
    output logic [7:0]  bus_nxt,
    output logic [2:0]  slot,
    output logic [15:0] rev_cnt,
    output logic        stall_ack
);

    typedef enum logic [1:0] {
        RUN_A = 2'd0,
        RUN_B = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk_cog or negedge nres) begin
        if (!nres) begin
            state_q <= RUN_A;
        end else begin
            state_q <= state_d;
        end
    end

    // Stall is only looked at on the edge that ends an ena_bus cycle, so a
    // freeze never splits a slot and a pulse confined to RUN_A is invisible.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN_A: state_d = RUN_B;
`ifdef HUB_SLOT_STALL_EN
            RUN_B: state_d = stall ? HALT : RUN_A;
            HALT:  state_d = stall ? HALT : RUN_A;
`else
            RUN_B: state_d = RUN_A;
            HALT:  state_d = RUN_A;
`endif
            default: state_d = RUN_A;
        endcase
    end

`ifndef HUB_SLOT_STALL_EN
    logic unused_stall;
    assign unused_stall = stall;
`endif

    // Strobes come straight from the state register: glitch-free and with no
    // combinational path from stall.
    assign ena_bus = (state_q == RUN_B);
`ifdef HUB_SLOT_STALL_EN
    assign stall_ack = (state_q == HALT);
`else
    assign stall_ack = 1'b0;
`endif

    // Slot registers advance only at the end of an ena_bus cycle; the advance
    // out of RUN_B happens even when that same edge enters HALT, so the
    // frozen slot is the next one in order.
    always_ff @(posedge clk_cog or negedge nres) begin
        if (!nres) begin
            bus_sel <= 8'h01;
            slot    <= 3'd0;
            rev_cnt <= 16'd0;
        end else if (ena_bus) begin
            bus_sel <= {bus_sel[6:0], bus_sel[7]};
            slot    <= slot + 3'd1;
            if (slot == 3'd7) begin
                rev_cnt <= rev_cnt + 16'd1;
            end
        end
    end

    assign bus_nxt = {bus_sel[6:0], bus_sel[7]};

endmodule

// File: tb/tb_hub_slot.sv
module tb_hub_slot;

    logic        clk_cog;
    logic        nres;
    logic        stall;
    logic        ena_bus;
    logic [7:0]  bus_sel;
    logic [7:0]  bus_nxt;
    logic [2:0]  slot;
    logic [15:0] rev_cnt;
    logic        stall_ack;

    hub_slot dut (
        .clk_cog   (clk_cog),
        .nres      (nres),
        .stall     (stall),
        .ena_bus   (ena_bus),
        .bus_sel   (bus_sel),
        .bus_nxt   (bus_nxt),
        .slot      (slot),
        .rev_cnt   (rev_cnt),
        .stall_ack (stall_ack)
    );

    initial clk_cog = 1'b0;
    always #5 clk_cog = ~clk_cog;

    typedef struct packed {
        logic [2:0]  slot;
        logic [15:0] rev;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic void push_pulse(input logic [2:0] s, input logic [15:0] r);
        exp_t e;
        e.slot = s;
        e.rev  = r;
        q.push_back(e);
    endfunction

    // Expected ena_bus pulses for an uninterrupted run from reset.
    function automatic void push_run(input int n);
        for (int k = 0; k < n; k++) begin
            push_pulse(3'(k % 8), 16'(k / 8));
        end
    endfunction

    // Monitor: every ena_bus pulse must match the next queued expectation.
    always @(negedge clk_cog) begin
        logic [7:0] want_sel;
        exp_t       e;
        if (nres === 1'b1) begin
            want_sel = 8'h01 << slot;
            check("onehot", {24'd0, bus_sel}, {24'd0, want_sel});
            check("bus_nxt", {24'd0, bus_nxt}, {24'd0, bus_sel[6:0], bus_sel[7]});
            if (ena_bus === 1'b1) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pulse_unexpected: got slot %0d required no pulse (t=%0t)", slot, $time);
                end else begin
                    e = q.pop_front();
                    want_sel = 8'h01 << e.slot;
                    check("pulse_slot", {29'd0, slot}, {29'd0, e.slot});
                    check("pulse_sel", {24'd0, bus_sel}, {24'd0, want_sel});
                    check("pulse_rev", {16'd0, rev_cnt}, {16'd0, e.rev});
                end
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_ena"}, {31'd0, ena_bus}, 32'd0);
        check({tag, "_sel"}, {24'd0, bus_sel}, 32'h01);
        check({tag, "_nxt"}, {24'd0, bus_nxt}, 32'h02);
        check({tag, "_slot"}, {29'd0, slot}, 32'd0);
        check({tag, "_rev"}, {16'd0, rev_cnt}, 32'd0);
        check({tag, "_ack"}, {31'd0, stall_ack}, 32'd0);
    endtask

    // Reset asserted just after a rising edge, held 3 cycles, released on a
    // falling edge so the first rising edge afterwards is "edge 1".
    task automatic do_reset();
        @(posedge clk_cog);
        #1 nres = 1'b0;
        #1 check_reset_vals("rst_now");
        check("q_empty", q.size(), 32'd0);
        q.delete();
        repeat (3) @(posedge clk_cog);
        @(negedge clk_cog);
        check_reset_vals("rst_hold");
        nres = 1'b1;
    endtask

    initial begin
        nres  = 1'b0;
        stall = 1'b0;

        // Reset release and rotation: 40 cycles, ena_bus on odd edges.
        do_reset();
        push_run(20);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_cog);
            @(negedge clk_cog);
            check("run_ena", {31'd0, ena_bus}, {31'd0, (i % 2) == 0});
            if (i == 31) check("run_rev2", {16'd0, rev_cnt}, 32'd2);
        end

        // Wrap: preload FFFF while idle in slot 7, next rotation wraps to 0.
        do_reset();
        push_run(7);
        push_pulse(3'd7, 16'hFFFF);
        push_pulse(3'd0, 16'h0000);
        repeat (14) @(posedge clk_cog);
        @(negedge clk_cog);
        check("wrap_pre_slot", {29'd0, slot}, 32'd7);
        force dut.rev_cnt = 16'hFFFF;
        #1 release dut.rev_cnt;
        repeat (2) @(posedge clk_cog);
        @(negedge clk_cog);
        check("wrap_rev", {16'd0, rev_cnt}, 32'h0000);
        check("wrap_slot", {29'd0, slot}, 32'd0);
        @(posedge clk_cog);
        @(negedge clk_cog);

`ifdef HUB_SLOT_STALL_EN
        // Stall requested during RUN_B of slot 3.
        do_reset();
        push_run(7);
        repeat (7) @(posedge clk_cog);
        @(negedge clk_cog);
        check("st_pre_slot", {29'd0, slot}, 32'd3);
        check("st_pre_ena", {31'd0, ena_bus}, 32'd1);
        stall = 1'b1;
        @(posedge clk_cog);
        @(negedge clk_cog);
        check("st_ack", {31'd0, stall_ack}, 32'd1);
        check("st_slot", {29'd0, slot}, 32'd4);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk_cog);
            @(negedge clk_cog);
            check("st_hold_ena", {31'd0, ena_bus}, 32'd0);
            check("st_hold_ack", {31'd0, stall_ack}, 32'd1);
        end
        stall = 1'b0;
        @(posedge clk_cog);
        @(negedge clk_cog);
        check("st_res_ack", {31'd0, stall_ack}, 32'd0);
        check("st_res_ena0", {31'd0, ena_bus}, 32'd0);
        @(posedge clk_cog);
        @(negedge clk_cog);
        check("st_res_ena1", {31'd0, ena_bus}, 32'd1);
        check("st_res_slot", {29'd0, slot}, 32'd4);
        // Pulse only across the RUN_A -> RUN_B edge: must not freeze.
        @(posedge clk_cog);
        @(negedge clk_cog);
        stall = 1'b1;
        @(posedge clk_cog);
        @(negedge clk_cog);
        check("sa_ack", {31'd0, stall_ack}, 32'd0);
        check("sa_ena", {31'd0, ena_bus}, 32'd1);
        check("sa_slot", {29'd0, slot}, 32'd5);
        stall = 1'b0;
        @(posedge clk_cog);
        @(negedge clk_cog);
        check("sa_ack2", {31'd0, stall_ack}, 32'd0);
        @(posedge clk_cog);
        @(negedge clk_cog);
        check("sa_ena2", {31'd0, ena_bus}, 32'd1);
        check("sa_slot2", {29'd0, slot}, 32'd6);

        // Async reset while halted at slot 5.
        do_reset();
        push_run(5);
        repeat (9) @(posedge clk_cog);
        @(negedge clk_cog);
        check("hr_pre_slot", {29'd0, slot}, 32'd4);
        stall = 1'b1;
        @(posedge clk_cog);
        @(negedge clk_cog);
        check("hr_ack", {31'd0, stall_ack}, 32'd1);
        check("hr_slot", {29'd0, slot}, 32'd5);
        #1 nres = 1'b0;
        #1 check("hr_ack_clr", {31'd0, stall_ack}, 32'd0);
        check("hr_slot_clr", {29'd0, slot}, 32'd0);
        check("hr_sel_clr", {24'd0, bus_sel}, 32'h01);
        stall = 1'b0;
`else
        // Stall held high: trace identical to a plain run, never acknowledged.
        stall = 1'b1;
        do_reset();
        push_run(25);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk_cog);
            @(negedge clk_cog);
            check("ns_ena", {31'd0, ena_bus}, {31'd0, (i % 2) == 0});
            check("ns_ack", {31'd0, stall_ack}, 32'd0);
        end
        stall = 1'b0;
`endif

        // Async reset in RUN_B of slot 7 with rev_cnt = 3.
        do_reset();
        push_run(32);
        repeat (63) @(posedge clk_cog);
        @(negedge clk_cog);
        check("mr_rev", {16'd0, rev_cnt}, 32'd3);
        check("mr_slot", {29'd0, slot}, 32'd7);
        check("mr_ena", {31'd0, ena_bus}, 32'd1);
        #1 nres = 1'b0;
        #1 check("mr_rev_clr", {16'd0, rev_cnt}, 32'd0);
        check("mr_slot_clr", {29'd0, slot}, 32'd0);
        check("mr_ena_clr", {31'd0, ena_bus}, 32'd0);
        check("mr_sel_clr", {24'd0, bus_sel}, 32'h01);

        repeat (2) @(posedge clk_cog);
        check("final_q_empty", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
